// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Holds the operation encoding and the signed-overflow rule.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // sr is the sign bit of the WIDTH-bit result
    function automatic logic ovf_calc(
        input op_e  op,
        input logic sa,
        input logic sb,
        input logic sr
    );
        logic same;
        same = (sa == sb);
        if (op == OP_ADD)
            return same && (sr != sa);
        else
            return !same && (sr != sa);
    endfunction

endpackage

// File: rtl/adder_seg.sv
// One pipeline segment: a SEG-bit slice add with registered carry,
// valid bit, load enable and pass-through operand registers.
module adder_seg
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_i,
    input  op_e              op_i,
    input  logic             c_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             dn_ready,
    output logic             up_ready,
    output logic             v_q,
    output op_e              op_q,
    output logic             c_q,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] s_q,
    output logic             ovf_q
);

    localparam int LO = IDX * SEG;

    logic [SEG-1:0]   bs;
    logic [SEG:0]     add;
    logic [WIDTH-1:0] s_d;
    logic             adv;

    always_comb begin
        bs  = (op_i == OP_SUB) ? ~b_i[LO +: SEG] : b_i[LO +: SEG];
        add = {1'b0, a_i[LO +: SEG]} + {1'b0, bs}
            + {{SEG{1'b0}}, c_i};
        s_d = s_i;
        s_d[LO +: SEG] = add[SEG-1:0];
    end

    // A full stage can still load if its beat leaves this cycle
    assign adv      = v_q && dn_ready;
    assign up_ready = !v_q || adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= 1'b0;
            op_q  <= OP_ADD;
            c_q   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (up_ready)
                v_q <= v_i;
            if (up_ready && v_i) begin
                op_q  <= op_i;
                c_q   <= add[SEG];
                a_q   <= a_i;
                b_q   <= b_i;
                s_q   <= s_d;
                ovf_q <= ovf_calc(op_i, a_i[WIDTH-1],
                                  b_i[WIDTH-1], s_d[WIDTH-1]);
            end
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES carry
// segments with valid/ready handshakes and collapsing bubbles.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    logic [STAGES:0]            v_c;
    logic [STAGES:0]            rdy_c;
    logic [STAGES:0]            c_c;
    op_e                        op_c [STAGES+1];
    logic [STAGES:0][WIDTH-1:0] a_c;
    logic [STAGES:0][WIDTH-1:0] b_c;
    logic [STAGES:0][WIDTH-1:0] s_c;
    logic [STAGES:1]            ovf_c;
    logic                       unused_ok;

    // Segment 0 takes the op bit as carry-in to form a - b
    assign v_c[0]         = in_valid;
    assign op_c[0]        = op;
    assign c_c[0]         = op;
    assign a_c[0]         = a;
    assign b_c[0]         = b;
    assign s_c[0]         = '0;
    assign rdy_c[STAGES]  = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        adder_seg #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (k)
        ) u_seg (
            .clk      (clk),
            .rst      (rst),
            .v_i      (v_c[k]),
            .op_i     (op_c[k]),
            .c_i      (c_c[k]),
            .a_i      (a_c[k]),
            .b_i      (b_c[k]),
            .s_i      (s_c[k]),
            .dn_ready (rdy_c[k+1]),
            .up_ready (rdy_c[k]),
            .v_q      (v_c[k+1]),
            .op_q     (op_c[k+1]),
            .c_q      (c_c[k+1]),
            .a_q      (a_c[k+1]),
            .b_q      (b_c[k+1]),
            .s_q      (s_c[k+1]),
            .ovf_q    (ovf_c[k+1])
        );
    end

    assign in_ready  = !rst && rdy_c[0];
    assign out_valid = v_c[STAGES];
    assign sum       = {c_c[STAGES], s_c[STAGES]};
    assign ovf       = ovf_c[STAGES];

    assign unused_ok = ^{a_c[STAGES], b_c[STAGES],
                         op_c[STAGES], ovf_c};

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed table, latency,
// backpressure, mid-flight reset and a random scoreboard stream.
module tb_pipe_adder;
    import adder_pkg::*;

    localparam int W = 16;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         op_b;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   sum;
    logic         ovf;

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_e'(op_b)),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   es;
        logic         eo;
    } vec_t;

    int           nvec = 0;
    int           errs = 0;
    int           n_acc = 0;
    int           n_out = 0;
    logic [W+1:0] sbq[$];
    logic [W:0]   drv_es;
    logic         drv_eo;
    logic         stall_prev = 1'b0;
    logic [W:0]   prev_sum;
    logic         prev_ovf;
    logic         rnd_mode = 1'b0;
    logic         bp_done;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic o,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic [W:0] s;
        int         r;
        logic       v;
        if (o) begin
            s = {1'b0, x} + 17'h10000 - {1'b0, y};
            r = int'($signed(x)) - int'($signed(y));
        end else begin
            s = {1'b0, x} + {1'b0, y};
            r = int'($signed(x)) + int'($signed(y));
        end
        v = (r > 32767) || (r < -32768);
        return {v, s};
    endfunction

    // Scoreboard: push on accept, pop/compare on consume
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst) begin
            sbq.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_sum", 32'(sum), 32'(prev_sum));
                chk("hold_ovf", 32'(ovf), 32'(prev_ovf));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sbq.size() == 0) begin
                    chk("unexpected_out", 32'(sum), 32'hDEAD);
                end else begin
                    e = sbq.pop_front();
                    chk("sum", 32'(sum), 32'(e[W:0]));
                    chk("ovf", 32'(ovf), 32'(e[W+1]));
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                sbq.push_back({drv_eo, drv_es});
            end
            stall_prev = out_valid && !out_ready;
            prev_sum   = sum;
            prev_ovf   = ovf;
        end
    end

    always @(posedge clk) begin
        if (rnd_mode) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W:0] es,
                        input logic eo);
        logic got;
        got      = 1'b0;
        op_b     = o;
        a        = x;
        b        = y;
        drv_es   = es;
        drv_eo   = eo;
        in_valid = 1'b1;
        for (int t = 0; t < 500 && !got; t++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 200 && sbq.size() != 0; t++)
            @(negedge clk);
        chk(nm, 32'(sbq.size()), 32'd0);
    endtask

    vec_t tbl[10];

    initial begin
        int           acc0;
        int           out0;
        logic [W+1:0] m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         ro;

        tbl[0] = '{1'b0, 16'hFFFF, 16'h0001, 17'h10000, 1'b0};
        tbl[1] = '{1'b0, 16'h7FFF, 16'h0001, 17'h08000, 1'b1};
        tbl[2] = '{1'b1, 16'h0005, 16'h0007, 17'h0FFFE, 1'b0};
        tbl[3] = '{1'b1, 16'h8000, 16'h0001, 17'h17FFF, 1'b1};
        tbl[4] = '{1'b1, 16'h0007, 16'h0005, 17'h10002, 1'b0};
        tbl[5] = '{1'b0, 16'h8000, 16'h8000, 17'h10000, 1'b1};
        tbl[6] = '{1'b1, 16'h0000, 16'h0000, 17'h10000, 1'b0};
        tbl[7] = '{1'b0, 16'h1234, 16'h4321, 17'h05555, 1'b0};
        tbl[8] = '{1'b1, 16'h7FFF, 16'hFFFF, 17'h08000, 1'b1};
        tbl[9] = '{1'b0, 16'h00FF, 16'h0001, 17'h00100, 1'b0};

        // Reset held two cycles with a beat presented
        rst       = 1'b1;
        in_valid  = 1'b1;
        op_b      = 1'b0;
        a         = 16'h1111;
        b         = 16'h2222;
        drv_es    = '0;
        drv_eo    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_no_accept", 32'(n_acc), 32'd0);

        // Latency with an empty pipe
        @(posedge clk);
        #1;
        send(tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].es, tbl[0].eo);
        @(negedge clk);
        chk("lat_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2", 32'(out_valid), 32'd1);
        drain("drain_lat");

        // Directed table, back to back
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++)
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].es, tbl[i].eo);
        drain("drain_table");

        // Backpressure: six beats, consumer stalled four cycles
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        acc0      = n_acc;
        out0      = n_out;
        bp_done   = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    m = model(1'b0, 16'(i * 16'h3001), 16'(i * 16'h1357));
                    send(1'b0, 16'(i * 16'h3001), 16'(i * 16'h1357),
                         m[W:0], m[W+1]);
                end
                bp_done = 1'b1;
            end
        join_none
        repeat (4) @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_accepted", 32'(n_acc - acc0), 32'd2);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int t = 0; t < 200 && !bp_done; t++) @(negedge clk);
        chk("bp_done", 32'(bp_done), 32'd1);
        drain("drain_bp");
        chk("bp_out_count", 32'(n_out - out0), 32'd6);

        // Reset with two beats in flight
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(1'b0, 16'h0101, 16'h0202, 17'h00303, 1'b0);
        send(1'b1, 16'h0404, 16'h0101, 17'h10303, 1'b0);
        out0 = n_out;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_out", 32'(n_out - out0), 32'd0);

        // Random stream against the reference model
        @(posedge clk);
        #1;
        acc0     = n_acc;
        out0     = n_out;
        rnd_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            ro = 1'($urandom_range(0, 1));
            ra = 16'($urandom());
            rb = 16'($urandom());
            m  = model(ro, ra, rb);
            send(ro, ra, rb, m[W:0], m[W+1]);
        end
        rnd_mode = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain("drain_rand");
        chk("rand_accepted", 32'(n_acc - acc0), 32'd1000);
        chk("rand_out_count", 32'(n_out - out0), 32'(n_acc - acc0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
